// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, captures {pc, instruction} pairs into a circular FIFO.
// Optional FETCH_QUEUE_BYPASS_EN presents imem data directly when the queue is empty.
module fetch_queue #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter int                    IM_BUS_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      halt,
  input  logic                      redirect,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic [IM_BUS_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]     imem_rdata,
  input  logic                      deq_ready,
  output logic                      deq_valid,
  output logic [DATA_WIDTH-1:0]     deq_pc,
  output logic [DATA_WIDTH-1:0]     deq_ir,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem_pc [DEPTH];
  logic [DATA_WIDTH-1:0] mem_ir [DEPTH];

  logic bypass;
  logic deq_fire;
  logic push;
  logic pop;
  logic advance;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && !redirect && !halt;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = !empty || bypass;
  assign deq_pc    = bypass ? fetch_pc   : mem_pc[rd_ptr];
  assign deq_ir    = bypass ? imem_rdata : mem_ir[rd_ptr];
  assign deq_fire  = deq_valid && deq_ready;

  // A bypassed entry taken straight by IF/ID never touches storage.
  assign pop     = deq_fire && !empty;
  assign push    = !redirect && !halt && (!full || deq_fire) && !(bypass && deq_ready);
  assign advance = push || (bypass && deq_ready);

  assign imem_addr = fetch_pc[IM_BUS_WIDTH+1:2];

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= fetch_pc;
      mem_ir[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~DATA_WIDTH'(3);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (advance) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
      if (push)    wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr   <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (default build): cycle table of control/status expectations plus a
// scoreboard of the expected in-order pc stream, reloaded at every redirect and reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_ir;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_pc      (deq_pc),
    .deq_ir      (deq_ir),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Instruction memory: word content is a tag xor the word address.
  assign imem_rdata = 32'hC0DE_0000 ^ {22'h0, imem_addr};

  int          n_vec  = 0;
  int          n_miss = 0;
  int          fires  = 0;
  logic [31:0] sb [$];

  typedef struct {
    logic        rdy;
    logic        hlt;
    logic        redir;
    logic [31:0] rpc;
    logic        val;
    logic [2:0]  cnt;
    logic [9:0]  addr;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ {22'h0, pc[11:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_load(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic observe();
    logic [31:0] e;
    if (deq_valid && deq_ready) begin
      fires++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_underflow: got pc %h expected no output", deq_pc);
      end else begin
        e = sb.pop_front();
        chk("deq_pc", deq_pc, e);
        chk("deq_ir", deq_ir, ir_of(e));
      end
    end
  endtask

  initial begin
    //            rdy   hlt   redir rpc            val   cnt   addr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 10'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd2};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd3};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd2, 10'd4};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd3, 10'd5};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd4, 10'd6};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd4, 10'd6};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd4, 10'd6};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd4, 10'd7};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd4, 10'd8};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h103,     1'b1, 3'd4, 10'd9};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 10'd64};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd65};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd66};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 3'd2, 10'd67};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 3'd1, 10'd67};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 3'd0, 10'd67};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 10'd67};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd68};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 32'h200,     1'b1, 3'd1, 10'd69};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 3'd0, 10'd128};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 10'd128};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 3'd1, 10'd129};

    rst         = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_ready   = 1'b0;

    #2;
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_load(32'h0);
    fires = 0;

    for (int i = 0; i < 24; i++) begin
      deq_ready   = tbl[i].rdy;
      halt        = tbl[i].hlt;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #3;
      chk("deq_valid", 32'(deq_valid), 32'(tbl[i].val));
      chk("count",     32'(count),     32'(tbl[i].cnt));
      chk("full",      32'(full),      32'(tbl[i].cnt == 3'd4));
      chk("empty",     32'(empty),     32'(tbl[i].cnt == 3'd0));
      chk("imem_addr", 32'(imem_addr), 32'(tbl[i].addr));
      observe();
      if (tbl[i].redir) sb_load(tbl[i].rpc & ~32'h3);
      @(posedge clk);
      #1;
    end
    chk("fires_table", 32'(fires), 32'd11);

    // Build up three entries, then hit the async reset between edges.
    deq_ready = 1'b0;
    halt      = 1'b0;
    redirect  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(deq_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_addr",  32'(imem_addr), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_full",  32'(full), 32'd0);

    @(negedge clk);
    rst       = 1'b1;
    deq_ready = 1'b1;
    sb_load(32'h0);
    fires = 0;
    #1;
    chk("restart_valid", 32'(deq_valid), 32'd0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #3;
      chk("restart_count", 32'(count), 32'd1);
      observe();
    end
    chk("fires_restart", 32'(fires), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
